// File: rtl/zerosoc_uart_rx.sv
`default_nettype none
// ============================================================================
// zerosoc_uart_rx : 8N1 UART receiver, mid-bit sampling, small receive FIFO
// Revision: 1.0
// ============================================================================
module zerosoc_uart_rx #(
  parameter int ClksPerBit = 16,
  parameter int FifoDepth  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rdata_o,
  output logic       rvalid_o,
  input  logic       rready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int CW = $clog2(ClksPerBit);
  localparam int AW = $clog2(FifoDepth);
  localparam logic [CW-1:0] CNT_HALF = CW'(ClksPerBit / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ClksPerBit - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [1:0]      sync_q;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  logic            push_req;
  logic            rx_s;

  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [FifoDepth];
  logic            full, empty, pop, push_ok;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_i};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = '0;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !empty && rready_i;
  assign push_ok    = push_req && (!full || pop);
  assign overflow_d = push_req && full && !pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign rdata_o     = mem_q[rd_ptr_q[AW-1:0]];
  assign rvalid_o    = !empty;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_zerosoc_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_zerosoc_uart_rx : directed bench for zerosoc_uart_rx (16 clk/bit, 4 deep)
// Revision: 1.0
// ============================================================================
module tb_zerosoc_uart_rx;

  localparam int ClksPerBit = 16;
  localparam int FifoDepth  = 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rready;
  logic [7:0] rdata;
  logic       rvalid;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  zerosoc_uart_rx #(
    .ClksPerBit (ClksPerBit),
    .FifoDepth  (FifoDepth)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int e0      = 0;

  // Event monitor, sampled on the falling edge.
  logic       prev_valid = 1'b0;
  int         rise_cyc   = -1;
  logic [7:0] rise_data  = 8'h00;
  int         valid_cnt  = 0;
  int         ferr_cnt   = 0;
  int         ovf_cnt    = 0;
  int         busy_cnt   = 0;
  int         both_cnt   = 0;
  int         ferr_cyc   = -1;
  int         ovf_cyc    = -1;

  always @(negedge clk) begin
    if (rvalid && !prev_valid) begin
      rise_cyc  = cyc;
      rise_data = rdata;
    end
    prev_valid = rvalid;
    if (rvalid)    valid_cnt = valid_cnt + 1;
    if (frame_err) begin ferr_cnt = ferr_cnt + 1; ferr_cyc = cyc; end
    if (overflow)  begin ovf_cnt = ovf_cnt + 1; ovf_cyc = cyc; end
    if (busy)      busy_cnt = busy_cnt + 1;
    if (frame_err && overflow) both_cnt = both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame LSB-first; optionally holds the line low afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int hold_bits, input int idle_clks);
    rx = 1'b0;
    e0 = cyc + 1;
    tick(ClksPerBit);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      tick(ClksPerBit);
    end
    rx = stop;
    tick(ClksPerBit);
    if (hold_bits > 0) begin
      rx = 1'b0;
      tick(hold_bits * ClksPerBit);
    end
    if (idle_clks > 0) begin
      rx = 1'b1;
      tick(idle_clks);
    end
  endtask

  // Pops four entries on consecutive cycles and checks each head byte.
  task automatic drain4(input string name, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] exp [4];
    exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({name, " valid"}, {31'd0, rvalid}, 32'd1);
      check({name, " data"}, {24'd0, rdata}, {24'd0, exp[i]});
    end
    @(negedge clk);
    check({name, " empty"}, {31'd0, rvalid}, 32'd0);
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  task automatic pop1;
    rready = 1'b1;
    tick(1);
    rready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];
  int   snap_v, snap_f, snap_o, snap_b;

  initial begin
    vecs[0] = '{data: 8'h01, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h01, exp_ferr: 0};
    vecs[1] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_ferr: 0};
    vecs[2] = '{data: 8'h7E, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1};
    vecs[3] = '{data: 8'hFE, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFE, exp_ferr: 0};
    vecs[4] = '{data: 8'h00, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1};
    vecs[5] = '{data: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h80, exp_ferr: 0};

    rst = 1'b1; rx = 1'b1; rready = 1'b0;
    tick(3);
    check("reset rvalid", {31'd0, rvalid}, 32'd0);
    check("reset rdata", {24'd0, rdata}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset ferr", {31'd0, frame_err}, 32'd0);
    check("reset ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Single byte latency with the consumer always ready.
    rready = 1'b1;
    snap_v = valid_cnt; snap_f = ferr_cnt; snap_o = ovf_cnt;
    send_frame(8'h55, 1'b1, 0, 16);
    check("lat rise", rise_cyc - e0, 32'd154);
    check("lat data", {24'd0, rise_data}, 32'h55);
    check("lat width", valid_cnt - snap_v, 32'd1);
    check("lat flags", (ferr_cnt - snap_f) + (ovf_cnt - snap_o), 32'd0);
    rready = 1'b0;

    // Table of single frames, each popped after inspection.
    foreach (vecs[k]) begin
      snap_f = ferr_cnt;
      send_frame(vecs[k].data, vecs[k].stop, 0, 16);
      check($sformatf("vec%0d valid", k), {31'd0, rvalid}, {31'd0, vecs[k].exp_valid});
      if (vecs[k].exp_valid) begin
        check($sformatf("vec%0d data", k), {24'd0, rdata}, {24'd0, vecs[k].exp_data});
        pop1();
      end
      check($sformatf("vec%0d ferr", k), ferr_cnt - snap_f, vecs[k].exp_ferr);
      check($sformatf("vec%0d drained", k), {31'd0, rvalid}, 32'd0);
    end

    // Back-to-back frames filling the FIFO, then consecutive pops.
    snap_o = ovf_cnt;
    send_frame(8'hA3, 1'b1, 0, 0);
    send_frame(8'h00, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b1, 0, 0);
    send_frame(8'h80, 1'b1, 0, 16);
    check("b2b ovf", ovf_cnt - snap_o, 32'd0);
    drain4("b2b", 8'hA3, 8'h00, 8'hFF, 8'h80);

    // Overflow with the consumer idle: fifth byte dropped.
    send_frame(8'h12, 1'b1, 0, 0);
    send_frame(8'h34, 1'b1, 0, 0);
    send_frame(8'h56, 1'b1, 0, 0);
    send_frame(8'h78, 1'b1, 0, 0);
    snap_o = ovf_cnt;
    send_frame(8'h11, 1'b1, 0, 16);
    check("ovf count", ovf_cnt - snap_o, 32'd1);
    check("ovf time", ovf_cyc - e0, 32'd154);
    drain4("ovf keep", 8'h12, 8'h34, 8'h56, 8'h78);

    // Overflow averted: pop coincides with the stop-bit sample.
    send_frame(8'h12, 1'b1, 0, 0);
    send_frame(8'h34, 1'b1, 0, 0);
    send_frame(8'h56, 1'b1, 0, 0);
    send_frame(8'h78, 1'b1, 0, 0);
    snap_o = ovf_cnt;
    fork
      send_frame(8'h11, 1'b1, 0, 16);
      begin
        repeat (154) @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
      end
    join
    check("popfull ovf", ovf_cnt - snap_o, 32'd0);
    drain4("popfull", 8'h34, 8'h56, 8'h78, 8'h11);

    // Framing error followed by a 40-bit break.
    snap_f = ferr_cnt;
    send_frame(8'h3C, 1'b0, 40, 0);
    @(negedge clk);
    check("brk busy", {31'd0, busy}, 32'd1);
    check("brk nopush", {31'd0, rvalid}, 32'd0);
    check("brk ferr", ferr_cnt - snap_f, 32'd1);
    check("brk ferr time", ferr_cyc - e0, 32'd154);
    @(posedge clk);
    #1 rx = 1'b1;
    tick(6);
    check("brk idle", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1, 0, 16);
    check("brk next valid", {31'd0, rvalid}, 32'd1);
    check("brk next data", {24'd0, rdata}, 32'h5A);
    pop1();

    // Glitch of 3 clocks: START for half a bit, then back to IDLE.
    snap_b = busy_cnt; snap_f = ferr_cnt; snap_o = ovf_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("glitch busy cycles", busy_cnt - snap_b, ClksPerBit / 2);
    check("glitch nopush", {31'd0, rvalid}, 32'd0);
    check("glitch flags", (ferr_cnt - snap_f) + (ovf_cnt - snap_o), 32'd0);

    // Reset in DATA bit 4 with two entries held.
    send_frame(8'h21, 1'b1, 0, 0);
    send_frame(8'h43, 1'b1, 0, 16);
    check("rstmid pre", {31'd0, rvalid}, 32'd1);
    fork
      send_frame(8'h99, 1'b1, 0, 16);
      begin
        repeat (82) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rstmid rvalid", {31'd0, rvalid}, 32'd0);
        check("rstmid rdata", {24'd0, rdata}, 32'd0);
        check("rstmid busy", {31'd0, busy}, 32'd0);
        check("rstmid flags", {30'd0, frame_err, overflow}, 32'd0);
      end
    join
    rst = 1'b0;
    tick(20);
    check("rstmid empty", {31'd0, rvalid}, 32'd0);
    send_frame(8'hC6, 1'b1, 0, 16);
    check("rstmid next valid", {31'd0, rvalid}, 32'd1);
    check("rstmid next data", {24'd0, rdata}, 32'hC6);
    pop1();
    check("flags exclusive", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
